// File: rtl/param_ring_counter_if.sv
// Control/status bundle for param_ring_counter: advance controls and load value in,
// counter state with wrap/err pulses out.
interface param_ring_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             mode;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out;
   logic             wrap;
   logic             err;

   modport master (
      output en, mode, dir, load, load_val,
      input  out, wrap, err
   );

   modport slave (
      input  en, mode, dir, load, load_val,
      output out, wrap, err
   );
endinterface

// File: rtl/param_ring_counter.sv
// WIDTH-bit one-hot / Johnson shift-ring sequencer with load, bidirectional advance and wrap pulse.
// Define SELF_CORRECT_EN to add illegal-state recovery to START with a one-cycle err pulse.
module param_ring_counter #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   param_ring_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] START = WIDTH'(1);

   logic [WIDTH-1:0] out_q, out_d, shifted;
   logic             mode_q, wrap_q, wrap_d, mode_chg, fb;

   assign mode_chg = bus.mode != mode_q;

   // Feedback bit is the bit leaving the ring, inverted in Johnson mode.
   assign fb      = (bus.dir ? out_q[0] : out_q[WIDTH-1]) ^ mode_q;
   assign shifted = bus.dir ? {fb, out_q[WIDTH-1:1]} : {out_q[WIDTH-2:0], fb};

`ifdef SELF_CORRECT_EN
   logic [WIDTH-1:0] inv;
   logic             legal, illegal, err_d, err_q;

   // Johnson codes are thermometer patterns from either end; ring codes are one-hot.
   always_comb begin
      inv = ~out_q;
      if (mode_q)
         legal = ((out_q & (out_q + START)) == '0) || ((inv & (inv + START)) == '0);
      else
         legal = (out_q != '0) && ((out_q & (out_q - START)) == '0);
   end

   assign illegal = !legal;
   assign err_d   = !bus.load && !mode_chg && bus.en && illegal;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      if (bus.load)
         out_d = bus.load_val;
      else if (mode_chg)
         out_d = START;
`ifdef SELF_CORRECT_EN
      else if (bus.en && illegal)
         out_d = START;
`endif
      else if (bus.en) begin
         out_d  = shifted;
         wrap_d = (shifted == START);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q  <= START;
         wrap_q <= 1'b0;
         mode_q <= bus.mode;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
         mode_q <= bus.mode;
      end
   end

   assign bus.out  = out_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_param_ring_counter.sv
// Randomized + directed bench for param_ring_counter against an arithmetic reference model.
// Honors SELF_CORRECT_EN the same way as the design.
module tb_param_ring_counter;
   localparam int W = 4;
   localparam int MASK = (1 << W) - 1;
   localparam logic [W-1:0] START = W'(1);
`ifdef SELF_CORRECT_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   param_ring_counter_if #(.WIDTH(W)) bus ();
   param_ring_counter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   logic [W-1:0] m_out;
   logic         m_wrap, m_err, m_mode_q;
   logic [W-1:0] jcodes [2*W];

   // Enumerate the 2*W Johnson codes: low-end and high-end thermometer fills.
   initial begin
      int n = 0;
      for (int k = 0; k <= W; k++) begin jcodes[n] = W'((1 << k) - 1); n++; end
      for (int k = 1; k < W; k++) begin jcodes[n] = W'(MASK & ~((1 << (W - k)) - 1)); n++; end
   end

   function automatic bit is_legal(input logic [W-1:0] x, input logic md);
      if (!md) return $countones(x) == 1;
      for (int k = 0; k < 2*W; k++) if (jcodes[k] == x) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] step(input logic [W-1:0] x, input logic md, input logic dr);
      int v   = int'(x);
      int msb = (v >> (W - 1)) & 1;
      int lsb = v & 1;
      if (!dr) v = ((v << 1) | (md ? 1 - msb : msb)) & MASK;
      else     v = (v >> 1) | ((md ? 1 - lsb : lsb) << (W - 1));
      return W'(v);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_out = START; m_wrap = 1'b0; m_err = 1'b0; m_mode_q = bus.mode;
      end else begin
         m_wrap = 1'b0; m_err = 1'b0;
         if (bus.load) m_out = bus.load_val;
         else if (bus.mode != m_mode_q) m_out = START;
         else if (bus.en) begin
            if (SC && !is_legal(m_out, m_mode_q)) begin
               m_out = START; m_err = 1'b1;
            end else begin
               m_out  = step(m_out, m_mode_q, bus.dir);
               m_wrap = (m_out == START);
            end
         end
         m_mode_q = bus.mode;
      end
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_out",  bus.out,       m_out);
         chk("model_wrap", W'(bus.wrap),  W'(m_wrap));
         chk("model_err",  W'(bus.err),   W'(m_err));
      end
   end

   // Apply one edge of stimulus and compare against hand-computed literals (DUT and model).
   task automatic st(input logic e, input logic md, input logic dr, input logic ld,
                     input logic [W-1:0] lv, input logic [W-1:0] eo, input logic ew, input logic ee);
      bus.en = e; bus.mode = md; bus.dir = dr; bus.load = ld; bus.load_val = lv;
      @(posedge clk); #1;
      chk("lit_out",   bus.out,      eo);
      chk("lit_wrap",  W'(bus.wrap), W'(ew));
      chk("lit_err",   W'(bus.err),  W'(ee));
      chk("lit_model", m_out,        eo);
      @(negedge clk); #1;
   endtask

   initial begin
      bus.en = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0; bus.load = 1'b0; bus.load_val = '0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      #1;
      chk("rst_out",  bus.out,      START);
      chk("rst_wrap", W'(bus.wrap), '0);
      chk("rst_err",  W'(bus.err),  '0);
      rst = 1'b1;

      // One-hot ring toward MSB
      st(1,0,0,0,'0, 4'b0010,0,0);
      st(1,0,0,0,'0, 4'b0100,0,0);
      st(1,0,0,0,'0, 4'b1000,0,0);
      st(1,0,0,0,'0, 4'b0001,1,0);
      // Johnson toward MSB; first edge is the mode change
      st(1,1,0,0,'0, 4'b0001,0,0);
      st(1,1,0,0,'0, 4'b0011,0,0);
      st(1,1,0,0,'0, 4'b0111,0,0);
      st(1,1,0,0,'0, 4'b1111,0,0);
      st(1,1,0,0,'0, 4'b1110,0,0);
      st(1,1,0,0,'0, 4'b1100,0,0);
      st(1,1,0,0,'0, 4'b1000,0,0);
      st(1,1,0,0,'0, 4'b0000,0,0);
      st(1,1,0,0,'0, 4'b0001,1,0);
      // Ring toward LSB
      st(1,0,1,0,'0, 4'b0001,0,0);
      st(1,0,1,0,'0, 4'b1000,0,0);
      st(1,0,1,0,'0, 4'b0100,0,0);
      st(1,0,1,0,'0, 4'b0010,0,0);
      st(1,0,1,0,'0, 4'b0001,1,0);
      // Johnson toward LSB
      st(1,1,1,0,'0, 4'b0001,0,0);
      st(1,1,1,0,'0, 4'b0000,0,0);
      st(1,1,1,0,'0, 4'b1000,0,0);
      st(1,1,1,0,'0, 4'b1100,0,0);
      st(1,1,1,0,'0, 4'b1110,0,0);
      st(1,1,1,0,'0, 4'b1111,0,0);
      st(1,1,1,0,'0, 4'b0111,0,0);
      st(1,1,1,0,'0, 4'b0011,0,0);
      st(1,1,1,0,'0, 4'b0001,1,0);
      // Hold, load over advance, mode toggle over advance
      st(0,1,0,0,'0, 4'b0001,0,0);
      st(0,1,0,0,'0, 4'b0001,0,0);
      st(0,1,0,0,'0, 4'b0001,0,0);
      st(1,1,0,1,4'b0100, 4'b0100,0,0);
      st(1,0,0,0,'0, 4'b0001,0,0);
      // Illegal ring pattern advanced
      st(0,0,0,1,4'b0101, 4'b0101,0,0);
`ifdef SELF_CORRECT_EN
      st(1,0,0,0,'0, 4'b0001,0,1);
`else
      st(1,0,0,0,'0, 4'b1010,0,0);
`endif
      st(0,0,0,1,4'b0001, 4'b0001,0,0);
      // Asynchronous reset between edges
      st(1,0,0,0,'0, 4'b0010,0,0);
      st(1,0,0,0,'0, 4'b0100,0,0);
      #2 rst = 1'b0;
      #1;
      chk("async_out",  bus.out,      START);
      chk("async_wrap", W'(bus.wrap), '0);
      chk("async_err",  W'(bus.err),  '0);
      @(negedge clk); #1 rst = 1'b1;
      st(1,0,0,0,'0, 4'b0010,0,0);
      st(1,0,0,0,'0, 4'b0100,0,0);

      // Randomized traffic, including illegal loads and occasional mid-cycle resets
      for (int i = 0; i < 3000; i++) begin
         bus.en       = ($urandom_range(0, 3) != 0);
         bus.dir      = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
         bus.load     = ($urandom_range(0, 15) == 0);
         bus.load_val = W'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #1 rst = 1'b0;
            #1 rst = 1'b1;
         end
         @(negedge clk); #1;
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
